// File: rtl/clk_ratio_meter.sv
`default_nettype none
// clk_ratio_meter -- times high/low phases of a divided clock in ref cycles,
// reports the period, declares lock and flags missing edges. Rev 1.0
module clk_ratio_meter #(
  parameter int RATIO_WIDTH = 8,
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_COUNT  = 4
) (
  input  logic                   I_ref_clk,
  input  logic                   I_rst_n,
  input  logic                   I_meas_en,
  input  logic                   I_div_clk,
  output logic [RATIO_WIDTH-1:0] o_ratio,
  output logic [RATIO_WIDTH-1:0] o_high_cnt,
  output logic [RATIO_WIDTH-1:0] o_low_cnt,
  output logic                   o_valid,
  output logic                   o_locked,
  output logic                   o_timeout
);

  localparam int                     MATCH_W  = $clog2(LOCK_COUNT + 1);
  localparam logic [RATIO_WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [RATIO_WIDTH-1:0] CNT_ONE  = RATIO_WIDTH'(1);
  localparam logic [MATCH_W-1:0]     LOCK_VAL = MATCH_W'(LOCK_COUNT);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_RISE = 2'd1,
    MEAS_HIGH = 2'd2,
    MEAS_LOW  = 2'd3
  } state_t;

  state_t                 state, state_nxt;
  logic [SYNC_STAGES-1:0] sync_ff;
  logic                   hist;
  logic                   rise, fall, edge_seen;
  logic [RATIO_WIDTH-1:0] cnt, cnt_nxt;
  logic [RATIO_WIDTH-1:0] high_q, high_nxt;
  logic [MATCH_W-1:0]     match_cnt, match_nxt;
  logic [RATIO_WIDTH:0]   sum;
  logic                   load, tmo;

  assign rise      = sync_ff[SYNC_STAGES-1] & ~hist;
  assign fall      = ~sync_ff[SYNC_STAGES-1] & hist;
  assign edge_seen = rise | fall;
  assign sum       = {1'b0, high_q} + {1'b0, cnt};

  always_ff @(posedge I_ref_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      sync_ff <= '0;
      hist    <= 1'b0;
    end else begin
      sync_ff <= {sync_ff[SYNC_STAGES-2:0], I_div_clk};
      hist    <= sync_ff[SYNC_STAGES-1];
    end
  end

  always_ff @(posedge I_ref_clk or negedge I_rst_n) begin
    if (!I_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    high_nxt  = high_q;
    match_nxt = match_cnt;
    load      = 1'b0;
    tmo       = 1'b0;
    if (!I_meas_en) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
      high_nxt  = '0;
      match_nxt = '0;
    end else if (state == IDLE) begin
      state_nxt = WAIT_RISE;
      cnt_nxt   = CNT_ONE;
    end else begin
      // Every edge restarts the phase count; a saturated count with no edge is a timeout.
      if (edge_seen) begin
        cnt_nxt = CNT_ONE;
      end else if (cnt == CNT_MAX) begin
        tmo       = 1'b1;
        cnt_nxt   = CNT_ONE;
        state_nxt = WAIT_RISE;
      end else begin
        cnt_nxt = cnt + 1'b1;
      end
      case (state)
        WAIT_RISE: if (rise) state_nxt = MEAS_HIGH;
        MEAS_HIGH: if (fall) begin
          high_nxt  = cnt;
          state_nxt = MEAS_LOW;
        end
        MEAS_LOW: if (rise) begin
          if (sum[RATIO_WIDTH]) begin
            tmo       = 1'b1;
            state_nxt = WAIT_RISE;
          end else begin
            load      = 1'b1;
            state_nxt = MEAS_HIGH;
          end
        end
        default: ;
      endcase
      if (tmo) begin
        match_nxt = '0;
      end else if (load) begin
        if (sum[RATIO_WIDTH-1:0] == o_ratio && match_cnt != '0)
          match_nxt = (match_cnt == LOCK_VAL) ? match_cnt : match_cnt + 1'b1;
        else
          match_nxt = MATCH_W'(1);
      end
    end
  end

  always_ff @(posedge I_ref_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      cnt        <= '0;
      high_q     <= '0;
      match_cnt  <= '0;
      o_ratio    <= '0;
      o_high_cnt <= '0;
      o_low_cnt  <= '0;
      o_valid    <= 1'b0;
      o_locked   <= 1'b0;
      o_timeout  <= 1'b0;
    end else begin
      cnt       <= cnt_nxt;
      high_q    <= high_nxt;
      match_cnt <= match_nxt;
      o_valid   <= load;
      o_locked  <= (match_nxt == LOCK_VAL);
      if (load) begin
        o_ratio    <= sum[RATIO_WIDTH-1:0];
        o_high_cnt <= high_q;
        o_low_cnt  <= cnt;
      end
      if (!I_meas_en || load) o_timeout <= 1'b0;
      else if (tmo)           o_timeout <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_clk_ratio_meter.sv
`default_nettype none
// tb_clk_ratio_meter -- random/directed stimulus checked every cycle against
// a timestamp-based reference model of the meter.
module tb_clk_ratio_meter;
  localparam int W     = 8;
  localparam int SYNC  = 2;
  localparam int LOCKN = 4;
  localparam int MAXC  = (1 << W) - 1;

  logic clk = 1'b0, rst_n = 1'b0, meas_en = 1'b0, div_clk = 1'b0;
  logic [W-1:0] ratio, high_cnt, low_cnt;
  logic valid, locked, timeout;

  clk_ratio_meter #(.RATIO_WIDTH(W), .SYNC_STAGES(SYNC), .LOCK_COUNT(LOCKN)) dut (
    .I_ref_clk(clk), .I_rst_n(rst_n), .I_meas_en(meas_en), .I_div_clk(div_clk),
    .o_ratio(ratio), .o_high_cnt(high_cnt), .o_low_cnt(low_cnt),
    .o_valid(valid), .o_locked(locked), .o_timeout(timeout)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Divided-clock generator: gen_h==0 means bypass (constant low).
  int gen_h = 0, gen_l = 0, ph = 0;
  always @(posedge clk) begin
    #2;
    if (gen_h == 0) begin
      div_clk = 1'b0;
      ph = 0;
    end else if (ph >= (div_clk ? gen_h : gen_l) - 1) begin
      div_clk = ~div_clk;
      ph = 0;
    end else begin
      ph++;
    end
  end

  // Reference model: edges are timestamps; phase lengths are time differences.
  logic [SYNC:0] dl = '0;
  int  cyc = 0, t_ref = 0, phase = 0, streak = 0, m_high = 0, m_low = 0;
  bit  armed = 0, dn, dd;
  logic [W-1:0] e_ratio = '0, e_high = '0, e_low = '0;
  bit  e_valid = 0, e_locked = 0, e_timeout = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dl = '0; armed = 0; phase = 0; streak = 0; t_ref = 0;
      e_ratio = '0; e_high = '0; e_low = '0;
      e_valid = 0; e_locked = 0; e_timeout = 0;
    end else begin
      dn = dl[SYNC-1];
      dd = dl[SYNC];
      dl = {dl[SYNC-1:0], div_clk};
      cyc++;
      e_valid = 0;
      if (!meas_en) begin
        armed = 0; e_locked = 0; e_timeout = 0; streak = 0;
      end else if (!armed) begin
        armed = 1; phase = 0; t_ref = cyc;
      end else if (dn != dd) begin
        if (phase == 0 && dn) phase = 1;
        else if (phase == 1 && !dn) begin m_high = cyc - t_ref; phase = 2; end
        else if (phase == 2 && dn) begin
          m_low = cyc - t_ref;
          if (m_high + m_low > MAXC) begin
            e_timeout = 1; streak = 0; e_locked = 0; phase = 0;
          end else begin
            if (m_high + m_low == int'(e_ratio) && streak != 0)
              streak = (streak < LOCKN) ? streak + 1 : LOCKN;
            else
              streak = 1;
            e_ratio = W'(m_high + m_low); e_high = W'(m_high); e_low = W'(m_low);
            e_valid = 1; e_timeout = 0; e_locked = (streak == LOCKN); phase = 1;
          end
        end
        t_ref = cyc;
      end else if (cyc - t_ref >= MAXC) begin
        e_timeout = 1; streak = 0; e_locked = 0; phase = 0; t_ref = cyc;
      end
    end
  end

  int vcount = 0;
  always @(negedge clk) begin
    chk("outs", {ratio, high_cnt, low_cnt, valid, locked, timeout},
                {e_ratio, e_high, e_low, e_valid, e_locked, e_timeout});
    if (valid) vcount++;
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    int i;
    cycles(3);
    chk("reset_outs", {ratio, high_cnt, low_cnt, valid, locked, timeout}, 0);
    rst_n = 1; meas_en = 1; gen_h = 2; gen_l = 2;
    cycles(60);
    chk("div4_ratio", ratio, 4); chk("div4_high", high_cnt, 2);
    chk("div4_low", low_cnt, 2); chk("div4_lock", locked, 1);

    gen_h = 3; gen_l = 2;
    cycles(60);
    chk("div5_ratio", ratio, 5); chk("div5_high", high_cnt, 3);
    chk("div5_low", low_cnt, 2); chk("div5_lock", locked, 1);

    gen_h = 3; gen_l = 3;
    for (i = 0; i < 60; i++) begin
      cycles(1);
      if (valid && ratio == 6) break;
    end
    chk("r6_seen", (valid && ratio == 6), 1);
    chk("r6_first_unlock", locked, 0);
    cycles(17);
    chk("r6_lock_pending", locked, 0);
    cycles(1);
    chk("r6_4th_valid", valid, 1);
    chk("r6_relock", locked, 1);

    // Bypass: constant divided clock must time out exactly MAXC cycles after arming.
    meas_en = 0; gen_h = 0;
    cycles(5);
    chk("dis_lock", locked, 0); chk("dis_tmo", timeout, 0); chk("dis_ratio", ratio, 6);
    meas_en = 1; vcount = 0;
    cycles(1);
    cycles(MAXC - 1);
    chk("tmo_early", timeout, 0);
    cycles(1);
    chk("tmo_255", timeout, 1);
    cycles(100);
    chk("bypass_no_valid", vcount, 0);

    gen_h = 4; gen_l = 4;
    for (i = 0; i < 60; i++) begin
      cycles(1);
      if (valid) break;
    end
    chk("div8_valid", valid, 1); chk("div8_ratio", ratio, 8); chk("div8_tmo_clr", timeout, 0);

    gen_h = 150; gen_l = 150;
    cycles(400);
    vcount = 0;
    cycles(1200);
    chk("ovf_no_valid", vcount, 0); chk("ovf_tmo", timeout, 1);
    chk("ovf_lock", locked, 0); chk("ovf_ratio_hold", ratio, 8);

    meas_en = 0; gen_h = 127; gen_l = 127;
    cycles(5);
    meas_en = 1;
    cycles(600);
    chk("d254_ratio", ratio, 254); chk("d254_high", high_cnt, 127);
    chk("d254_low", low_cnt, 127); chk("d254_tmo", timeout, 0);

    for (int k = 0; k < 10; k++) begin
      gen_h = $urandom_range(1, 40);
      gen_l = $urandom_range(1, 40);
      if ($urandom_range(0, 7) == 0) gen_h = 0;
      meas_en = ($urandom_range(0, 5) != 0);
      if ($urandom_range(0, 6) == 0) begin
        rst_n = 0;
        cycles(2);
        rst_n = 1;
      end
      cycles($urandom_range(50, 400));
    end

    // Reset in the middle of a low phase, then disable while locked.
    meas_en = 1; gen_h = 5; gen_l = 5;
    cycles(120);
    chk("pre_rst_lock", locked, 1);
    for (i = 0; i < 40 && phase != 2; i++) cycles(1);
    chk("meas_low_wait", phase, 2);
    cycles(2);
    rst_n = 0;
    #1;
    chk("rst_mid_outs", {ratio, high_cnt, low_cnt, valid, locked, timeout}, 0);
    cycles(2);
    rst_n = 1;
    cycles(100);
    chk("relock", locked, 1); chk("relock_ratio", ratio, 10);
    meas_en = 0;
    cycles(2);
    chk("en_low_lock", locked, 0); chk("en_low_tmo", timeout, 0);
    chk("en_low_valid", valid, 0); chk("en_low_ratio", ratio, 10);
    cycles(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
